// File: rtl/fp8_e4m3_pack_sched.sv
`default_nettype none
// fp8_e4m3_pack_sched (rev 1.0): round-robin scheduler sharing one FP32->E4M3 converter and packing BPW bytes per word.
// Optional feature macro: FP8_PACK_SAT_CNT_EN enables the saturation counter on sat_cnt_o.

module fp8_e4m3_pack (
   input  logic [31:0] fp32_i,
   output logic [7:0]  fp8_o,
   output logic        sat_o
);
   logic [7:0]  exp_w;
   logic [7:0]  shd_w;
   logic [4:0]  sh_w;
   logic [8:0]  ebase_w;
   logic [55:0] ext_w;
   logic        rnd_w;
   logic [11:0] mag_w;

   always_comb begin
      exp_w = fp32_i[30:23];
      shd_w = 8'd121 - exp_w;
      // Exponents below 121 land in the E4M3 subnormal range: denormalise by shifting right.
      if (exp_w >= 8'd121) begin
         sh_w    = 5'd0;
         ebase_w = {1'b0, exp_w - 8'd121};
      end else begin
         sh_w    = (shd_w > 8'd31) ? 5'd31 : shd_w[4:0];
         ebase_w = 9'd0;
      end
      ext_w = {1'b1, fp32_i[22:0], 32'd0} >> sh_w;
      rnd_w = ext_w[51] & (ext_w[52] | (|ext_w[50:0]));
      // The hidden bit adds one exponent step, so the rounding carry ripples into the exponent naturally.
      mag_w = {ebase_w, 3'b000} + {8'd0, ext_w[55:52]} + {11'd0, rnd_w};

      sat_o = 1'b0;
      if (exp_w == 8'hFF) begin
         fp8_o = {fp32_i[31], 4'hF, (fp32_i[22:0] != 23'd0) ? 3'b001 : 3'b000};
      end else if (exp_w == 8'h00) begin
         fp8_o = {fp32_i[31], 7'h00};
      end else if (mag_w > 12'h077) begin
         fp8_o = {fp32_i[31], 7'h77};
         sat_o = 1'b1;
      end else begin
         fp8_o = {fp32_i[31], mag_w[6:0]};
      end
   end
endmodule

module fp8_e4m3_pack_sched #(
   parameter int N_REQ     = 4,
   parameter int BPW       = 4,
   parameter int SAT_CNT_W = 16
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [N_REQ-1:0]                  req_valid_i,
   input  logic [32*N_REQ-1:0]               req_data_i,
   output logic [N_REQ-1:0]                  req_ready_o,
   input  logic                              flush_i,
   output logic                              out_valid_o,
   input  logic                              out_ready_i,
   output logic [8*BPW-1:0]                  out_data_o,
   output logic [$clog2(BPW+1)-1:0]          out_cnt_o,
   output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] out_src_o,
   output logic [BPW-1:0]                    out_sat_o,
   input  logic                              sat_clr_i,
   output logic [SAT_CNT_W-1:0]              sat_cnt_o
);
   localparam int CNT_W = $clog2(BPW+1);
   localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_EMIT    = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [SRC_W-1:0]   owner_q, owner_d;
   logic [SRC_W-1:0]   rr_q, rr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [8*BPW-1:0]   data_q, data_d;
   logic [BPW-1:0]     flags_q, flags_d;

   logic [SRC_W-1:0]   pick_w;
   logic               found_w;
   int                 idx_w;
   logic               acc_w;
   logic [7:0]         conv_byte_w;
   logic               conv_sat_w;

   fp8_e4m3_pack u_conv (
      .fp32_i (req_data_i[{owner_q, 5'b00000} +: 32]),
      .fp8_o  (conv_byte_w),
      .sat_o  (conv_sat_w)
   );

   // Round-robin: first valid requester at or after the pointer, wrapping.
   always_comb begin
      pick_w  = rr_q;
      found_w = 1'b0;
      idx_w   = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx_w = int'(rr_q) + i;
         if (idx_w >= N_REQ) idx_w = idx_w - N_REQ;
         if (!found_w && req_valid_i[SRC_W'(idx_w)]) begin
            found_w = 1'b1;
            pick_w  = SRC_W'(idx_w);
         end
      end
   end

   always_comb begin
      req_ready_o = '0;
      if (state_q == S_COLLECT) req_ready_o[owner_q] = 1'b1;
   end

   assign acc_w = (state_q == S_COLLECT) && req_valid_i[owner_q];

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      count_d = count_q;
      data_d  = data_q;
      flags_d = flags_q;
      case (state_q)
         S_IDLE: begin
            if (|req_valid_i) begin
               owner_d = pick_w;
               state_d = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (acc_w) begin
               data_d[{count_q, 3'b000} +: 8] = conv_byte_w;
               flags_d[count_q]               = conv_sat_w;
               count_d                        = count_q + 1'b1;
            end
            // Flush sees the count after any same-cycle accept.
            if (count_d == CNT_W'(BPW)) begin
               state_d = S_EMIT;
            end else if (flush_i) begin
               state_d = (count_d == '0) ? S_IDLE : S_EMIT;
            end
         end
         S_EMIT: begin
            if (out_ready_i) begin
               state_d = S_IDLE;
               count_d = '0;
               data_d  = '0;
               flags_d = '0;
               rr_d    = (owner_q == SRC_W'(N_REQ-1)) ? '0 : owner_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         owner_q <= '0;
         rr_q    <= '0;
         count_q <= '0;
         data_q  <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         count_q <= count_d;
         data_q  <= data_d;
         flags_q <= flags_d;
      end
   end

   assign out_valid_o = (state_q == S_EMIT);
   assign out_data_o  = data_q;
   assign out_cnt_o   = count_q;
   assign out_src_o   = owner_q;
   assign out_sat_o   = flags_q;

`ifdef FP8_PACK_SAT_CNT_EN
   logic [SAT_CNT_W-1:0] sat_cnt_q;

   // Clear wins over a same-cycle increment; the count sticks at all-ones.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sat_cnt_q <= '0;
      end else if (sat_clr_i) begin
         sat_cnt_q <= '0;
      end else if (acc_w && conv_sat_w && !(&sat_cnt_q)) begin
         sat_cnt_q <= sat_cnt_q + 1'b1;
      end
   end

   assign sat_cnt_o = sat_cnt_q;
`else
   logic unused_sat_clr_w;
   assign unused_sat_clr_w = sat_clr_i;
   assign sat_cnt_o        = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_fp8_e4m3_pack_sched.sv
`default_nettype none
// tb_fp8_e4m3_pack_sched: randomized words checked against a nearest-value E4M3 model and a round-robin scoreboard.
module tb_fp8_e4m3_pack_sched;
   localparam int N_REQ     = 4;
   localparam int BPW       = 4;
   localparam int SAT_CNT_W = 16;

   logic                 clk_i = 1'b0;
   logic                 rst_ni;
   logic [N_REQ-1:0]     req_valid_i;
   logic [32*N_REQ-1:0]  req_data_i;
   logic [N_REQ-1:0]     req_ready_o;
   logic                 flush_i;
   logic                 out_valid_o;
   logic                 out_ready_i;
   logic [8*BPW-1:0]     out_data_o;
   logic [2:0]           out_cnt_o;
   logic [1:0]           out_src_o;
   logic [BPW-1:0]       out_sat_o;
   logic                 sat_clr_i;
   logic [SAT_CNT_W-1:0] sat_cnt_o;

   always #5 clk_i = ~clk_i;

   fp8_e4m3_pack_sched #(.N_REQ(N_REQ), .BPW(BPW), .SAT_CNT_W(SAT_CNT_W)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid_i),
      .req_data_i  (req_data_i),
      .req_ready_o (req_ready_o),
      .flush_i     (flush_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_cnt_o   (out_cnt_o),
      .out_src_o   (out_src_o),
      .out_sat_o   (out_sat_o),
      .sat_clr_i   (sat_clr_i),
      .sat_cnt_o   (sat_cnt_o)
   );

   int n_checks = 0;
   int n_errors = 0;
   int m_rr     = 0;
   int m_satcnt = 0;
   logic [31:0]      word_in [BPW];
   logic [8*BPW-1:0] last_data;
   logic [2:0]       last_cnt;
   logic [1:0]       last_src;
   logic [BPW-1:0]   last_sat;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Reference conversion: nearest E4M3 value (ties to even code); 256 stands for "beyond the top code".
   function automatic logic [8:0] model_conv(input logic [31:0] b);
      real x, v, d, bd;
      int  best, e;
      e = int'(b[30:23]);
      if (e == 255) return (b[22:0] != 23'd0) ? {1'b0, b[31], 7'h79} : {1'b0, b[31], 7'h78};
      if (e == 0) x = 0.0;
      else x = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
      best = 0;
      bd   = x;
      for (int c = 1; c <= 120; c++) begin
         if (c < 8) v = real'(c) * (2.0 ** (-9));
         else v = (1.0 + real'(c % 8) / 8.0) * (2.0 ** (c / 8 - 7));
         d = (x > v) ? x - v : v - x;
         if (d < bd || (d == bd && (c % 2) == 0)) begin
            bd   = d;
            best = c;
         end
      end
      if (best == 120) return {1'b1, b[31], 7'h77};
      return {1'b0, b[31], 7'(best)};
   endfunction

   function automatic logic [31:0] rand_fp32();
      logic s;
      logic [22:0] m;
      s = 1'($urandom);
      m = 23'($urandom);
      case ($urandom_range(0, 19))
         0:       return {s, 31'd0};
         1:       return {s, 8'hFF, 23'd0};
         2:       return {s, 8'hFF, m | 23'd1};
         3:       return {s, 8'($urandom_range(105, 140)), m[22:20], 1'b1, 19'd0};
         default: return {s, 8'($urandom_range(105, 140)), m};
      endcase
   endfunction

   function automatic int exp_owner(input logic [N_REQ-1:0] mask);
      for (int i = 0; i < N_REQ; i++) begin
         if (mask[(m_rr + i) % N_REQ]) return (m_rr + i) % N_REQ;
      end
      return 0;
   endfunction

   task automatic rand_lanes();
      for (int k = 0; k < N_REQ; k++) req_data_i[k*32 +: 32] = $urandom;
   endtask

   task automatic run_word(input logic [N_REQ-1:0] mask, input int n, input bit rnd,
                           input bit flush_last, input int stall, input bit gaps);
      int owner, acc, guard;
      bit v;
      logic [31:0] d;
      logic [31:0] got [$];
      logic [8:0] r;
      logic [8*BPW-1:0] ed;
      logic [BPW-1:0] es;
      owner = exp_owner(mask);
      check("idle_ready", 64'(req_ready_o), 64'd0);
      check("idle_valid", 64'(out_valid_o), 64'd0);
      req_valid_i = mask;
      rand_lanes();
      tick();
      acc   = 0;
      guard = 0;
      while (acc < n && guard < 200) begin
         guard++;
         check("collect_ready", 64'(req_ready_o), 64'(1 << owner));
         v = !gaps || ($urandom_range(0, 3) != 0);
         d = rnd ? rand_fp32() : word_in[acc];
         rand_lanes();
         req_data_i[owner*32 +: 32] = d;
         req_valid_i        = mask;
         req_valid_i[owner] = v;
         flush_i = v && (acc + 1 == n) && flush_last;
         if (v) begin
            got.push_back(d);
            acc++;
         end
         tick();
         flush_i = 1'b0;
      end
      if (acc < n) check("collect_timeout", 64'(acc), 64'(n));
      if (n < BPW && !flush_last) begin
         req_valid_i[owner] = 1'b0;
         flush_i = 1'b1;
         tick();
         flush_i = 1'b0;
      end
      ed = '0;
      es = '0;
      foreach (got[j]) begin
         r = model_conv(got[j]);
         ed[8*j +: 8] = r[7:0];
         es[j] = r[8];
         if (r[8] && m_satcnt < (1 << SAT_CNT_W) - 1) m_satcnt++;
      end
      req_valid_i = mask;
      out_ready_i = 1'b0;
      for (int s = 0; s <= stall; s++) begin
         check("emit_valid", 64'(out_valid_o), 64'd1);
         check("emit_data", 64'(out_data_o), 64'(ed));
         check("emit_cnt", 64'(out_cnt_o), 64'(got.size()));
         check("emit_src", 64'(out_src_o), 64'(owner));
         check("emit_sat", 64'(out_sat_o), 64'(es));
         check("emit_ready", 64'(req_ready_o), 64'd0);
`ifdef FP8_PACK_SAT_CNT_EN
         check("sat_cnt", 64'(sat_cnt_o), 64'(m_satcnt));
`else
         check("sat_cnt", 64'(sat_cnt_o), 64'd0);
`endif
         if (s == stall) out_ready_i = 1'b1;
         last_data = out_data_o;
         last_cnt  = out_cnt_o;
         last_src  = out_src_o;
         last_sat  = out_sat_o;
         tick();
      end
      out_ready_i = 1'b0;
      req_valid_i = '0;
      m_rr = (owner + 1) % N_REQ;
      check("post_emit_valid", 64'(out_valid_o), 64'd0);
   endtask

   task automatic flush_zero(input logic [N_REQ-1:0] mask);
      int owner;
      owner = exp_owner(mask);
      req_valid_i = mask;
      tick();
      check("fz_ready", 64'(req_ready_o), 64'(1 << owner));
      req_valid_i = '0;
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      check("fz_valid", 64'(out_valid_o), 64'd0);
      check("fz_idle_ready", 64'(req_ready_o), 64'd0);
      tick();
      check("fz_valid2", 64'(out_valid_o), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int order [5];
      int exp_order [5];
      exp_order   = '{0, 1, 2, 3, 0};
      rst_ni      = 1'b0;
      req_valid_i = '0;
      req_data_i  = '0;
      flush_i     = 1'b0;
      out_ready_i = 1'b0;
      sat_clr_i   = 1'b0;
      repeat (3) tick();
      check("rst_valid", 64'(out_valid_o), 64'd0);
      check("rst_data", 64'(out_data_o), 64'd0);
      check("rst_cnt", 64'(out_cnt_o), 64'd0);
      check("rst_ready", 64'(req_ready_o), 64'd0);
      check("rst_satcnt", 64'(sat_cnt_o), 64'd0);
      rst_ni = 1'b1;
      tick();

      for (int w = 0; w < 5; w++) begin
         run_word('1, BPW, 1'b1, 1'b0, 0, 1'b0);
         order[w] = int'(last_src);
      end
      for (int w = 0; w < 5; w++) check("rr_order", 64'(order[w]), 64'(exp_order[w]));

      word_in = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'hBF000000};
      run_word(4'b0001, BPW, 1'b0, 1'b0, 0, 1'b0);
      check("t1_data", 64'(last_data), 64'hB0444038);
      check("t1_cnt", 64'(last_cnt), 64'd4);
      check("t1_src", 64'(last_src), 64'd0);
      check("t1_sat", 64'(last_sat), 64'd0);

      sat_clr_i = 1'b1;
      tick();
      sat_clr_i = 1'b0;
      m_satcnt  = 0;
      check("satclr", 64'(sat_cnt_o), 64'd0);
      word_in = '{32'h43960000, 32'h43960000, 32'h43960000, 32'h43960000};
      run_word(4'b0100, BPW, 1'b0, 1'b0, 0, 1'b0);
      check("t2_data", 64'(last_data), 64'h77777777);
      check("t2_sat", 64'(last_sat), 64'hF);
`ifdef FP8_PACK_SAT_CNT_EN
      check("t2_satcnt", 64'(sat_cnt_o), 64'd4);
`else
      check("t2_satcnt", 64'(sat_cnt_o), 64'd0);
`endif

      word_in = '{32'h7FC00000, 32'hFF800000, 32'h0, 32'h0};
      run_word(4'b0010, 2, 1'b0, 1'b0, 0, 1'b0);
      check("t4_data", 64'(last_data), 64'h0000F879);
      check("t4_cnt", 64'(last_cnt), 64'd2);
      check("t4_sat", 64'(last_sat), 64'd0);

      run_word(4'b1011, BPW, 1'b1, 1'b0, 5, 1'b0);
      flush_zero('1);
      run_word('1, 3, 1'b1, 1'b1, 1, 1'b0);
      run_word('1, BPW, 1'b1, 1'b1, 0, 1'b0);

      for (int w = 0; w < 40; w++) begin
         run_word(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), $urandom_range(1, BPW),
                  1'b1, 1'($urandom), $urandom_range(0, 3), 1'b1);
      end

      req_valid_i = 4'b1000;
      tick();
      check("rst_mid_grant", 64'(req_ready_o), 64'(1 << exp_owner(4'b1000)));
      req_data_i[3*32 +: 32] = 32'h3F800000;
      tick();
      tick();
      #2;
      rst_ni = 1'b0;
      #1;
      check("rstmid_valid", 64'(out_valid_o), 64'd0);
      check("rstmid_data", 64'(out_data_o), 64'd0);
      check("rstmid_cnt", 64'(out_cnt_o), 64'd0);
      check("rstmid_src", 64'(out_src_o), 64'd0);
      check("rstmid_ready", 64'(req_ready_o), 64'd0);
      req_valid_i = '0;
      tick();
      tick();
      rst_ni   = 1'b1;
      m_rr     = 0;
      m_satcnt = 0;
      run_word('1, 1, 1'b1, 1'b1, 0, 1'b0);
      check("post_rst_src", 64'(last_src), 64'd0);
      run_word('1, BPW, 1'b1, 1'b0, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
